// File: rtl/ones_count_pkg.sv
// Shared widths and FSM encoding for the OnesCount feeder and the OnesCount core.
// Both blocks must use the same word and count widths.
package ones_count_pkg;
    localparam int WORD_W = 30;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RELEASE = 2'd2
    } feeder_state_t;
endpackage

// File: rtl/ones_count_feeder_if.sv
// Word ingress, OnesCount handshake and result/status bundle for the feeder.
// The slave modport is the feeder's own view of these signals.
interface ones_count_feeder_if
    import ones_count_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic [WORD_W-1:0]        word_in;
    logic                     word_valid;
    logic                     word_ready;
    logic [WORD_W-1:0]        d_in;
    logic                     d_in_ready;
    logic                     dor;
    logic [CNT_W-1:0]         d_out;
    logic [CNT_W-1:0]         result;
    logic                     result_valid;
    logic [$clog2(DEPTH):0]   occupancy;
    logic                     error;

    modport slave (
        input  word_in, word_valid, dor, d_out,
        output word_ready, d_in, d_in_ready, result, result_valid, occupancy, error
    );

    modport master (
        output word_in, word_valid, dor, d_out,
        input  word_ready, d_in, d_in_ready, result, result_valid, occupancy, error
    );
endinterface

// File: rtl/ones_count_feeder_word_fifo.sv
// Synchronous FIFO: registered count, head visible combinationally on dout.
// Push is dropped when full and pop when empty; both may happen on one edge.
module word_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits, so they wrap modulo DEPTH for free.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/ones_count_feeder.sv
// Queues words and hands them one at a time to OnesCount; result one edge after dor.
// word_ready drops when the queue is full; a stuck OnesCount raises a sticky error.
module ones_count_feeder
    import ones_count_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    ones_count_feeder_if.slave bus
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    feeder_state_t     r_state;
    logic [TW-1:0]     r_timer;
    logic [CNT_W-1:0]  r_result;
    logic              r_result_valid;
    logic              r_error;

    logic              w_full;
    logic              w_empty;
    logic [OW-1:0]     w_count;
    logic [WORD_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;

    assign w_push = bus.word_valid & ~w_full;
    assign w_pop  = (r_state == START) & bus.dor;

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.word_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign bus.word_ready   = ~w_full;
    assign bus.d_in         = w_empty ? '0 : w_head;
    assign bus.d_in_ready   = (r_state == START);
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.occupancy    = w_count;
    assign bus.error        = r_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_timer        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_count != '0) r_state <= START;
                end
                START: begin
                    if (bus.dor) begin
                        r_result       <= bus.d_out;
                        r_result_valid <= 1'b1;
                        r_timer        <= '0;
                        r_state        <= RELEASE;
                    end else if (r_timer != TW'(TIMEOUT)) begin
                        r_timer <= r_timer + 1'b1;
                        if (r_timer == TW'(TIMEOUT - 1)) r_error <= 1'b1;
                    end
                end
                // Holding here until dor drops keeps a long dor from popping twice.
                RELEASE: begin
                    if (!bus.dor) r_state <= (w_count != '0) ? START : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ones_count_feeder.sv
// Directed bench for ones_count_feeder with a behavioural OnesCount responder.
module tb_ones_count_feeder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ones_count_feeder_if #(.DEPTH(4)) bus ();

    ones_count_feeder #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [29:0] word;
        logic [5:0]  exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          m_delay = 31;
    int          m_extra = 0;
    int          m_cyc = 0;
    int          m_hold = 0;
    int          m_dor_edges = 0;
    logic [29:0] m_word = '0;
    bit          stable_bad = 0;
    bit          overlap_bad = 0;

    logic [5:0]  got[$];
    int          rv_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // OnesCount model: dor after m_delay cycles of d_in_ready, held m_extra extra cycles.
    always @(posedge clock) begin
        if (reset || !bus.dor) m_dor_edges = 0;
        else m_dor_edges = m_dor_edges + 1;
    end

    always @(negedge clock) begin
        if (reset) begin
            bus.dor = 1'b0; bus.d_out = '0; m_cyc = 0; m_hold = 0;
        end else begin
            if (bus.dor && m_dor_edges > 0 && bus.d_in_ready) overlap_bad = 1;
            if (bus.dor) begin
                if (m_hold > 0) m_hold--;
                else bus.dor = 1'b0;
            end else if (bus.d_in_ready) begin
                m_cyc++;
                if (m_cyc == 1) m_word = bus.d_in;
                else if (bus.d_in !== m_word) stable_bad = 1;
                if (m_cyc >= m_delay) begin
                    bus.dor   = 1'b1;
                    bus.d_out = 6'($countones(bus.d_in));
                    m_hold    = m_extra;
                    m_cyc     = 0;
                end
            end else begin
                m_cyc = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && bus.result_valid) begin
            got.push_back(bus.result);
            rv_count++;
            chk("gap_dinrdy_low", 32'(bus.d_in_ready), 32'd0);
        end
    end

    task automatic push_word(input logic [29:0] w);
        @(negedge clock);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.word_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (got.size() < n) begin
            errors++;
            $display("FAIL wait_results actual=%0d required=%0d", got.size(), n);
        end
    endtask

    vec_t tbl[6];

    initial begin
        int base;
        int rv0;
        int k;
        tbl[0] = '{30'h3FFFFFFF, 6'd30};
        tbl[1] = '{30'h00000000, 6'd0};
        tbl[2] = '{30'h00000001, 6'd1};
        tbl[3] = '{30'h2AAAAAAA, 6'd15};
        tbl[4] = '{30'h0000F0F0, 6'd8};
        tbl[5] = '{30'h20000001, 6'd2};

        bus.word_in = '0; bus.word_valid = 1'b0;

        // 1: reset
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_d_in_ready", 32'(bus.d_in_ready), 0);
        chk("rst_word_ready", 32'(bus.word_ready), 1);
        chk("rst_occupancy", 32'(bus.occupancy), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_d_in", 32'(bus.d_in), 0);
        @(negedge clock);
        reset = 1'b0;

        // 2: single word, latency and pulse width
        base = got.size(); rv0 = rv_count;
        push_word(30'h3FFF);
        chk("t2_rdy_not_yet", 32'(bus.d_in_ready), 0);
        @(posedge clock); #1;
        chk("t2_rdy_one_edge", 32'(bus.d_in_ready), 1);
        chk("t2_d_in", 32'(bus.d_in), 32'h3FFF);
        wait_results(base + 1, 100);
        if (got.size() > base) chk("t2_result", 32'(got[base]), 14);
        @(negedge clock);
        chk("t2_rv_pulse", 32'(bus.result_valid), 0);
        repeat (3) @(negedge clock);
        chk("t2_rv_count", 32'(rv_count - rv0), 1);
        chk("t2_idle_rdy", 32'(bus.d_in_ready), 0);
        chk("t2_idle_occ", 32'(bus.occupancy), 0);
        chk("t2_stable", 32'(stable_bad), 0);

        // 3: back-to-back fill, full drop, in-order results
        base = got.size();
        for (int i = 0; i < 4; i++) push_word(tbl[i].word);
        chk("t3_full_wr_rdy", 32'(bus.word_ready), 0);
        chk("t3_full_occ", 32'(bus.occupancy), 4);
        push_word(30'h3);
        chk("t3_drop_occ", 32'(bus.occupancy), 4);
        wait_results(base + 4, 400);
        for (int i = 0; i < 4; i++)
            if (got.size() > base + i) chk($sformatf("t3_res%0d", i), 32'(got[base + i]), 32'(tbl[i].exp));
        for (int i = 4; i < 6; i++) begin
            push_word(tbl[i].word);
            wait_results(base + i + 1, 100);
            if (got.size() > base + i) chk($sformatf("t3_res%0d", i), 32'(got[base + i]), 32'(tbl[i].exp));
        end
        repeat (4) @(negedge clock);
        chk("t3_drained_occ", 32'(bus.occupancy), 0);
        chk("t3_result_count", 32'(got.size() - base), 6);
        chk("t3_stable", 32'(stable_bad), 0);

        // 4: dor held 3 extra cycles
        m_extra = 3;
        base = got.size(); rv0 = rv_count;
        push_word(30'h155);
        push_word(30'h7);
        wait_results(base + 2, 200);
        if (got.size() > base + 1) begin
            chk("t4_res0", 32'(got[base]), 5);
            chk("t4_res1", 32'(got[base + 1]), 3);
        end
        repeat (8) @(negedge clock);
        chk("t4_rv_count", 32'(rv_count - rv0), 2);
        chk("t4_occ", 32'(bus.occupancy), 0);
        chk("t4_overlap", 32'(overlap_bad), 0);
        m_extra = 0;

        // 5: timeout
        m_delay = 70;
        base = got.size();
        push_word(30'h1);
        k = 0;
        while (!bus.d_in_ready && k < 10) begin @(negedge clock); k++; end
        chk("t5_start", 32'(bus.d_in_ready), 1);
        repeat (62) @(negedge clock);
        chk("t5_err_early", 32'(bus.error), 0);
        repeat (3) @(negedge clock);
        chk("t5_err_set", 32'(bus.error), 1);
        chk("t5_rdy_held", 32'(bus.d_in_ready), 1);
        wait_results(base + 1, 100);
        if (got.size() > base) chk("t5_result", 32'(got[base]), 1);
        repeat (3) @(negedge clock);
        chk("t5_err_sticky", 32'(bus.error), 1);
        m_delay = 31;

        // 6: reset while in START with two words queued
        base = got.size();
        push_word(30'hFF);
        push_word(30'hF);
        chk("t6_pre_rdy", 32'(bus.d_in_ready), 1);
        chk("t6_pre_occ", 32'(bus.occupancy), 2);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_rdy", 32'(bus.d_in_ready), 0);
        chk("t6_occ", 32'(bus.occupancy), 0);
        chk("t6_err", 32'(bus.error), 0);
        chk("t6_wr_rdy", 32'(bus.word_ready), 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("t6_no_result", 32'(got.size() - base), 0);
        chk("t6_idle_rdy", 32'(bus.d_in_ready), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
